// File: rtl/mbus_tx_sequencer.sv
// MBus layer-side transmit sequencer: buffers DEPTH words and sends them as one message over the
// TX_REQ/TX_ACK/TX_PEND handshake. Define MBUS_TX_RETRY_EN to re-send a failed message up to 2 extra times.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module mbus_tx_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [`DATA_WIDTH-1:0] WR_DATA,
  input  logic                   WR_EN,
  output logic                   WR_OVF,
  input  logic [`ADDR_WIDTH-1:0] MSG_ADDR,
  input  logic                   MSG_PRIORITY,
  input  logic                   START,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   DONE_FAIL,
  output logic [PTR_W:0]         WORD_CNT,
  output logic [`ADDR_WIDTH-1:0] TX_ADDR,
  output logic [`DATA_WIDTH-1:0] TX_DATA,
  output logic                   TX_REQ,
  output logic                   TX_PEND,
  output logic                   PRIORITY,
  input  logic                   TX_ACK,
  input  logic                   TX_SUCC,
  input  logic                   TX_FAIL,
  output logic                   TX_RESP_ACK
);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, ACKLOW, WAIT_RES, RESP, FIN} state_t;

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] ONE_CNT  = {{PTR_W{1'b0}}, 1'b1};

  state_t                 state;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   fail;
  logic                   resp_seen;
  logic                   push;
  logic [`DATA_WIDTH-1:0] mem [DEPTH];
`ifdef MBUS_TX_RETRY_EN
  logic [PTR_W-1:0]       sh_ptr;
  logic [PTR_W:0]         sh_cnt;
  logic [1:0]             tries;
`endif

  // Words are only accepted while idle; the buffer is frozen for the whole message.
  assign push = WR_EN && (state == IDLE) && (WORD_CNT != FULL_CNT);

  // NOTE: the word storage has no reset; validity is tracked by WORD_CNT and the pointers,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

  // NOTE: every register here uses <= so all branches see the pre-edge values of state,
  // WORD_CNT and the pointers, regardless of statement order.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fail        <= 1'b0;
      resp_seen   <= 1'b0;
      WR_OVF      <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DONE_FAIL   <= 1'b0;
      WORD_CNT    <= '0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_REQ      <= 1'b0;
      TX_PEND     <= 1'b0;
      PRIORITY    <= 1'b0;
      TX_RESP_ACK <= 1'b0;
`ifdef MBUS_TX_RETRY_EN
      sh_ptr      <= '0;
      sh_cnt      <= '0;
      tries       <= '0;
`endif
    end else begin
      WR_OVF    <= WR_EN && !push;
      DONE      <= 1'b0;
      DONE_FAIL <= 1'b0;

      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        WORD_CNT <= WORD_CNT + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (START && (WORD_CNT != '0)) begin
            TX_ADDR   <= MSG_ADDR;
            PRIORITY  <= MSG_PRIORITY;
            BUSY      <= 1'b1;
            fail      <= 1'b0;
            resp_seen <= 1'b0;
            state     <= LOAD;
`ifdef MBUS_TX_RETRY_EN
            sh_ptr    <= rd_ptr;
            sh_cnt    <= WORD_CNT + {{PTR_W{1'b0}}, push};
            tries     <= '0;
`endif
          end
        end

        LOAD: begin
          TX_DATA <= mem[rd_ptr];
          TX_PEND <= (WORD_CNT > ONE_CNT);
          TX_REQ  <= 1'b1;
          state   <= REQ;
        end

        REQ, ACKLOW: begin
          if (TX_FAIL) begin
            // Bus abort mid-message: stop requesting and go straight to acknowledging the result.
            TX_REQ      <= 1'b0;
            TX_PEND     <= 1'b0;
            TX_RESP_ACK <= 1'b1;
            fail        <= 1'b1;
            state       <= RESP;
`ifndef MBUS_TX_RETRY_EN
            rd_ptr      <= wr_ptr;
            WORD_CNT    <= '0;
`endif
          end else if (state == REQ) begin
            if (TX_ACK) begin
              TX_REQ   <= 1'b0;
              rd_ptr   <= rd_ptr + 1'b1;
              WORD_CNT <= WORD_CNT - 1'b1;
              state    <= ACKLOW;
            end
          end else begin
            // An early success on the last word is remembered so WAIT_RES does not miss it.
            if (TX_SUCC && (WORD_CNT == '0)) resp_seen <= 1'b1;
            if (!TX_ACK) begin
              if (WORD_CNT != '0) begin
                state <= LOAD;
              end else begin
                TX_PEND <= 1'b0;
                state   <= WAIT_RES;
              end
            end
          end
        end

        WAIT_RES: begin
          if (TX_SUCC || TX_FAIL || resp_seen) begin
            fail        <= TX_FAIL;
            TX_RESP_ACK <= 1'b1;
            state       <= RESP;
          end
        end

        RESP: begin
          if (!TX_SUCC && !TX_FAIL) begin
            TX_RESP_ACK <= 1'b0;
            resp_seen   <= 1'b0;
`ifdef MBUS_TX_RETRY_EN
            if (fail && (tries != 2'd2)) begin
              tries    <= tries + 2'd1;
              rd_ptr   <= sh_ptr;
              WORD_CNT <= sh_cnt;
              fail     <= 1'b0;
              state    <= LOAD;
            end else begin
              rd_ptr   <= wr_ptr;
              WORD_CNT <= '0;
              state    <= FIN;
            end
`else
            state <= FIN;
`endif
          end
        end

        FIN: begin
          DONE      <= 1'b1;
          DONE_FAIL <= fail;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_tx_sequencer.sv
// Directed bench for mbus_tx_sequencer: a wrapper-side model answers the handshake while a
// scoreboard of expected words and completion status is compared against the DUT.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_mbus_tx_sequencer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct {
    logic [`DATA_WIDTH-1:0] data;
    logic                   pend;
  } word_t;

  logic                   CLK = 1'b0;
  logic                   RESETn = 1'b0;
  logic [`DATA_WIDTH-1:0] WR_DATA = '0;
  logic                   WR_EN = 1'b0;
  logic                   WR_OVF;
  logic [`ADDR_WIDTH-1:0] MSG_ADDR = '0;
  logic                   MSG_PRIORITY = 1'b0;
  logic                   START = 1'b0;
  logic                   BUSY;
  logic                   DONE;
  logic                   DONE_FAIL;
  logic [PTR_W:0]         WORD_CNT;
  logic [`ADDR_WIDTH-1:0] TX_ADDR;
  logic [`DATA_WIDTH-1:0] TX_DATA;
  logic                   TX_REQ;
  logic                   TX_PEND;
  logic                   PRIORITY;
  logic                   TX_ACK = 1'b0;
  logic                   TX_SUCC = 1'b0;
  logic                   TX_FAIL = 1'b0;
  logic                   TX_RESP_ACK;

  int total = 0;
  int bad   = 0;

  logic [`DATA_WIDTH-1:0] mdl_buf [$];
  word_t                  exp_q [$];
  logic                   exp_done_q [$];
  logic [`ADDR_WIDTH-1:0] exp_addr;
  logic                   exp_pri;

  mbus_tx_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .WR_DATA(WR_DATA), .WR_EN(WR_EN), .WR_OVF(WR_OVF),
    .MSG_ADDR(MSG_ADDR), .MSG_PRIORITY(MSG_PRIORITY), .START(START),
    .BUSY(BUSY), .DONE(DONE), .DONE_FAIL(DONE_FAIL), .WORD_CNT(WORD_CNT),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
    .PRIORITY(PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return TX_REQ;
      1:       return TX_RESP_ACK;
      2:       return DONE;
      default: return 1'b0;
    endcase
  endfunction

  // Polls on falling edges for a bounded number of cycles; an expired bound is a failed check.
  task automatic wait_lvl(input string tag, input int which, input logic lvl);
    int n = 0;
    while (sig(which) !== lvl && n < 64) begin
      @(negedge CLK);
      n++;
    end
    check(tag, sig(which), lvl);
  endtask

  task automatic push_word(input logic [`DATA_WIDTH-1:0] d);
    logic exp_ovf;
    exp_ovf = (mdl_buf.size() >= DEPTH);
    if (!exp_ovf) mdl_buf.push_back(d);
    @(negedge CLK);
    WR_DATA = d;
    WR_EN   = 1'b1;
    @(negedge CLK);
    WR_EN   = 1'b0;
    check("wr_ovf", WR_OVF, exp_ovf);
    check("word_cnt_push", WORD_CNT, mdl_buf.size());
  endtask

  task automatic start_msg(input logic [`ADDR_WIDTH-1:0] addr, input logic pri, input logic exp_fail);
    int n = mdl_buf.size();
    exp_addr = addr;
    exp_pri  = pri;
    for (int i = 0; i < n; i++) begin
      word_t w;
      w.data = mdl_buf.pop_front();
      w.pend = (i != n - 1);
      exp_q.push_back(w);
    end
    exp_done_q.push_back(exp_fail);
    @(negedge CLK);
    MSG_ADDR     = addr;
    MSG_PRIORITY = pri;
    START        = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", BUSY, 1'b1);
    check("req_lat_cycle1", TX_REQ, 1'b0);
    @(negedge CLK);
    check("req_lat_cycle2", TX_REQ, 1'b1);
  endtask

  // Wrapper model: acks every expected word; optionally aborts with TX_FAIL after word fail_after.
  task automatic serve_msg(input int fail_after, input logic succ, input logic fl);
    int  n = exp_q.size();
    logic exp_fail;
    for (int i = 0; i < n; i++) begin
      word_t w;
      wait_lvl("req_rise", 0, 1'b1);
      w = exp_q.pop_front();
      check("tx_data", TX_DATA, w.data);
      check("tx_pend", TX_PEND, w.pend);
      check("tx_addr", TX_ADDR, exp_addr);
      check("priority", PRIORITY, exp_pri);
      TX_ACK = 1'b1;
      wait_lvl("req_fall", 0, 1'b0);
      TX_ACK = 1'b0;
      if (i == fail_after) begin
        TX_FAIL = 1'b1;
        exp_q.delete();
        break;
      end
    end
    if (fail_after < 0) begin
      @(negedge CLK);
      check("pend_low_wait_res", TX_PEND, 1'b0);
      TX_SUCC = succ;
      TX_FAIL = fl;
    end
    wait_lvl("resp_ack_rise", 1, 1'b1);
    check("req_low_in_resp", TX_REQ, 1'b0);
    repeat (2) @(negedge CLK);
    check("resp_ack_held", TX_RESP_ACK, 1'b1);
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    wait_lvl("resp_ack_fall", 1, 1'b0);
    wait_lvl("done_rise", 2, 1'b1);
    exp_fail = exp_done_q.pop_front();
    check("done_fail", DONE_FAIL, exp_fail);
    check("busy_at_done", BUSY, 1'b0);
    check("word_cnt_at_done", WORD_CNT, 0);
    @(negedge CLK);
    check("done_pulse", DONE, 1'b0);
  endtask

  initial begin
    logic seen_req, seen_done, seen_busy;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_busy", BUSY, 1'b0);
    check("rst_req", TX_REQ, 1'b0);
    RESETn = 1'b1;
    @(negedge CLK);
    check("rst_word_cnt", WORD_CNT, 0);
    check("rst_done", DONE, 1'b0);
    check("rst_resp_ack", TX_RESP_ACK, 1'b0);

    // Two-word message, success
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    start_msg(32'h12, 1'b0, 1'b0);
    serve_msg(-1, 1'b1, 1'b0);

    // Overflow on the fifth push, then a four-word message across the pointer wrap
    for (int i = 0; i < DEPTH + 1; i++) push_word(32'hC0DE_0000 + i);
    @(negedge CLK);
    check("wr_ovf_single_pulse", WR_OVF, 1'b0);
    check("word_cnt_full", WORD_CNT, DEPTH);
    start_msg(32'h3C, 1'b1, 1'b0);
    serve_msg(-1, 1'b1, 1'b0);

    // START with an empty buffer is ignored
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    seen_req = 1'b0; seen_done = 1'b0; seen_busy = 1'b0;
    repeat (6) begin
      seen_req  |= TX_REQ;
      seen_done |= DONE;
      seen_busy |= BUSY;
      @(negedge CLK);
    end
    check("empty_start_req", seen_req, 1'b0);
    check("empty_start_done", seen_done, 1'b0);
    check("empty_start_busy", seen_busy, 1'b0);

    // Three words, bus abort after the second ACK
    push_word(32'h1111_0000);
    push_word(32'h2222_0000);
    push_word(32'h3333_0000);
    start_msg(32'h55, 1'b0, 1'b1);
    serve_msg(1, 1'b0, 1'b0);

    // Reset while a word is being requested
    push_word(32'hDEAD_0001);
    push_word(32'hDEAD_0002);
    start_msg(32'h77, 1'b0, 1'b0);
    exp_q.delete();
    exp_done_q.delete();
    #2 RESETn = 1'b0;
    #1;
    check("rst_mid_req", TX_REQ, 1'b0);
    check("rst_mid_busy", BUSY, 1'b0);
    check("rst_mid_word_cnt", WORD_CNT, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    seen_req = 1'b0; seen_done = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      seen_req  |= TX_REQ;
      seen_done |= DONE;
    end
    check("post_rst_no_req", seen_req, 1'b0);
    check("post_rst_no_done", seen_done, 1'b0);

    // TX_SUCC and TX_FAIL together in WAIT_RES: failure wins
    push_word(32'hBEEF_0001);
    start_msg(32'h9A, 1'b1, 1'b1);
    serve_msg(-1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
